// File: rtl/ahb_rr_arbiter.sv
// Round-robin, burst-aware AHB-Lite arbiter: MANAGERS manager ports onto one main bus.
// Define AHB_ARB_LOCK_EN to add HMASTLOCK ports and locked-sequence arbitration hold.
module ahb_rr_arbiter #(
    parameter int unsigned MANAGERS = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDW      = $clog2(MANAGERS)
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [2*MANAGERS-1:0]        m_HTRANS,
    input  logic [ADDR_W*MANAGERS-1:0]   m_HADDR,
    input  logic [MANAGERS-1:0]          m_HWRITE,
    input  logic [3*MANAGERS-1:0]        m_HSIZE,
    input  logic [3*MANAGERS-1:0]        m_HBURST,
    input  logic [DATA_W*MANAGERS-1:0]   m_HWDATA,
`ifdef AHB_ARB_LOCK_EN
    input  logic [MANAGERS-1:0]          m_HMASTLOCK,
    output logic                         s_HMASTLOCK,
`endif
    output logic [MANAGERS-1:0]          m_HREADY,
    output logic [MANAGERS-1:0]          m_HRESP,
    output logic [DATA_W*MANAGERS-1:0]   m_HRDATA,
    output logic [1:0]                   s_HTRANS,
    output logic [ADDR_W-1:0]            s_HADDR,
    output logic                         s_HWRITE,
    output logic [2:0]                   s_HSIZE,
    output logic [2:0]                   s_HBURST,
    output logic [DATA_W-1:0]            s_HWDATA,
    input  logic                         s_HREADY,
    input  logic                         s_HRESP,
    input  logic [DATA_W-1:0]            s_HRDATA,
    output logic [IDW-1:0]               HMASTER,
    output logic [MANAGERS-1:0]          HGRANT
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_INCR   = 3'd1;
    localparam logic [2:0] BU_WRAP4  = 3'd2;
    localparam logic [2:0] BU_INCR4  = 3'd3;
    localparam logic [2:0] BU_WRAP8  = 3'd4;
    localparam logic [2:0] BU_INCR8  = 3'd5;

    logic [IDW-1:0]      addr_owner;
    logic [IDW-1:0]      data_owner;
    logic [IDW-1:0]      rr_ptr;
    logic                data_valid;
    logic                locked;
    logic [4:0]          beats_left;

    logic [1:0]          own_trans;
    logic [ADDR_W-1:0]   own_addr;
    logic                own_write;
    logic [2:0]          own_size;
    logic [2:0]          own_burst;
    logic [DATA_W-1:0]   dat_wdata;
    logic [MANAGERS-1:0] req;
    logic                lock_nxt;
    logic [4:0]          beats_nxt;
    logic                found;
    logic [IDW-1:0]      winner;
    logic                arb_en;

    // Address-phase fields from addr_owner, write data from data_owner
    always_comb begin
        own_trans = TR_IDLE;
        own_addr  = '0;
        own_write = 1'b0;
        own_size  = '0;
        own_burst = '0;
        dat_wdata = '0;
        req       = '0;
        for (int unsigned i = 0; i < MANAGERS; i++) begin
            req[i] = (m_HTRANS[2*i +: 2] != TR_IDLE);
            if (IDW'(i) == addr_owner) begin
                own_trans = m_HTRANS[2*i +: 2];
                own_addr  = m_HADDR[ADDR_W*i +: ADDR_W];
                own_write = m_HWRITE[i];
                own_size  = m_HSIZE[3*i +: 3];
                own_burst = m_HBURST[3*i +: 3];
            end
            if (IDW'(i) == data_owner)
                dat_wdata = m_HWDATA[DATA_W*i +: DATA_W];
        end
    end

    // Burst lock tracking; beats_left only reaches 1 -> 0 on fixed-length bursts
    always_comb begin
        lock_nxt  = locked;
        beats_nxt = beats_left;
        case (own_trans)
            TR_NONSEQ: begin
                lock_nxt = 1'b1;
                case (own_burst)
                    BU_SINGLE:          begin lock_nxt = 1'b0; beats_nxt = 5'd0; end
                    BU_INCR:            beats_nxt = 5'd0;
                    BU_WRAP4, BU_INCR4: beats_nxt = 5'd3;
                    BU_WRAP8, BU_INCR8: beats_nxt = 5'd7;
                    default:            beats_nxt = 5'd15;
                endcase
            end
            TR_SEQ: begin
                if (beats_left != 5'd0) begin
                    beats_nxt = beats_left - 5'd1;
                    if (beats_left == 5'd1)
                        lock_nxt = 1'b0;
                end
            end
            TR_BUSY: ;
            default: lock_nxt = 1'b0;
        endcase
    end

    // Round-robin search starting just above rr_ptr, wrapping to rr_ptr itself
    always_comb begin
        found  = 1'b0;
        winner = addr_owner;
        for (int unsigned i = 0; i < MANAGERS; i++) begin
            if (!found && req[i] && (IDW'(i) > rr_ptr)) begin
                found  = 1'b1;
                winner = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < MANAGERS; i++) begin
            if (!found && req[i] && (IDW'(i) <= rr_ptr)) begin
                found  = 1'b1;
                winner = IDW'(i);
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic own_mastlock;
    always_comb begin
        own_mastlock = 1'b0;
        for (int unsigned i = 0; i < MANAGERS; i++)
            if (IDW'(i) == addr_owner)
                own_mastlock = m_HMASTLOCK[i];
    end
    assign s_HMASTLOCK = own_mastlock;
    assign arb_en      = !lock_nxt && !own_mastlock;
`else
    assign arb_en      = !lock_nxt;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner <= '0;
            data_owner <= '0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            beats_left <= 5'd0;
            rr_ptr     <= '0;
        end else if (s_HREADY) begin
            data_valid <= own_trans[1];
            data_owner <= addr_owner;
            locked     <= lock_nxt;
            beats_left <= beats_nxt;
            if (arb_en && found) begin
                addr_owner <= winner;
                rr_ptr     <= winner;
            end
        end
    end

    // Main-bus request and per-manager response routing
    always_comb begin
        s_HTRANS = HRESETn ? own_trans : TR_IDLE;
        s_HADDR  = own_addr;
        s_HWRITE = own_write;
        s_HSIZE  = own_size;
        s_HBURST = own_burst;
        s_HWDATA = dat_wdata;
        HMASTER  = addr_owner;
        HGRANT   = '0;
        m_HREADY = '0;
        m_HRESP  = '0;
        m_HRDATA = '0;
        for (int unsigned i = 0; i < MANAGERS; i++) begin
            HGRANT[i] = (IDW'(i) == addr_owner);
            if ((IDW'(i) == addr_owner) || (data_valid && (IDW'(i) == data_owner)))
                m_HREADY[i] = s_HREADY;
            if (data_valid && (IDW'(i) == data_owner)) begin
                m_HRESP[i]                    = s_HRESP;
                m_HRDATA[DATA_W*i +: DATA_W]  = s_HRDATA;
            end
        end
        if (!HRESETn)
            m_HREADY = '1;
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: directed manager traffic, monitor checks accepted addresses.
module tb_ahb_rr_arbiter;

    localparam int unsigned M  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [2*M-1:0]    m_HTRANS;
    logic [AW*M-1:0]   m_HADDR;
    logic [M-1:0]      m_HWRITE;
    logic [3*M-1:0]    m_HSIZE;
    logic [3*M-1:0]    m_HBURST;
    logic [DW*M-1:0]   m_HWDATA;
    logic [M-1:0]      m_HREADY;
    logic [M-1:0]      m_HRESP;
    logic [DW*M-1:0]   m_HRDATA;
    logic [1:0]        s_HTRANS;
    logic [AW-1:0]     s_HADDR;
    logic              s_HWRITE;
    logic [2:0]        s_HSIZE;
    logic [2:0]        s_HBURST;
    logic [DW-1:0]     s_HWDATA;
    logic              s_HREADY;
    logic              s_HRESP;
    logic [DW-1:0]     s_HRDATA;
    logic [IW-1:0]     HMASTER;
    logic [M-1:0]      HGRANT;
`ifdef AHB_ARB_LOCK_EN
    logic [M-1:0]      m_HMASTLOCK;
    logic              s_HMASTLOCK;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];

    ahb_rr_arbiter #(.MANAGERS(M), .ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_HTRANS(m_HTRANS), .m_HADDR(m_HADDR), .m_HWRITE(m_HWRITE),
        .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HWDATA(m_HWDATA),
`ifdef AHB_ARB_LOCK_EN
        .m_HMASTLOCK(m_HMASTLOCK), .s_HMASTLOCK(s_HMASTLOCK),
`endif
        .m_HREADY(m_HREADY), .m_HRESP(m_HRESP), .m_HRDATA(m_HRDATA),
        .s_HTRANS(s_HTRANS), .s_HADDR(s_HADDR), .s_HWRITE(s_HWRITE),
        .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST), .s_HWDATA(s_HWDATA),
        .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .s_HRDATA(s_HRDATA),
        .HMASTER(HMASTER), .HGRANT(HGRANT)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_mgr(input int i, input logic [1:0] tr, input logic [31:0] a,
                           input logic [2:0] bu, input logic wr);
        m_HTRANS[2*i +: 2]  = tr;
        m_HADDR[AW*i +: AW] = a;
        m_HBURST[3*i +: 3]  = bu;
        m_HSIZE[3*i +: 3]   = 3'b010;
        m_HWRITE[i]         = wr;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] a, input logic [1:0] tr, input logic wr);
        exp_t e;
        e.id = id; e.addr = a; e.trans = tr; e.wr = wr;
        exp_q.push_back(e);
    endtask

    task automatic all_idle();
        for (int i = 0; i < int'(M); i++)
            set_mgr(i, IDLE, 32'h0, SINGLE, 1'b0);
    endtask

    // Monitor: every address the main bus accepts must match the next scoreboard entry
    initial begin
        exp_t e;
        logic [M-1:0] g;
        forever begin
            @(negedge HCLK);
            if (HRESETn === 1'b1 && s_HREADY === 1'b1 && s_HTRANS[1] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got id=%0d addr=%0h trans=%0d t=%0t",
                             HMASTER, s_HADDR, s_HTRANS, $time);
                end else begin
                    e = exp_q.pop_front();
                    g = 4'b0001 << e.id;
                    if ({HMASTER, s_HADDR, s_HTRANS, s_HWRITE, HGRANT} !== {e.id, e.addr, e.trans, e.wr, g}) begin
                        failures++;
                        $display("FAIL sb_xfer got id=%0d addr=%0h tr=%0d wr=%0b gnt=%b exp id=%0d addr=%0h tr=%0d wr=%0b gnt=%b t=%0t",
                                 HMASTER, s_HADDR, s_HTRANS, s_HWRITE, HGRANT,
                                 e.id, e.addr, e.trans, e.wr, g, $time);
                    end
                end
            end
        end
    end

    initial begin
        HRESETn  = 1'b0;
        s_HREADY = 1'b1;
        s_HRESP  = 1'b0;
        s_HRDATA = '0;
        m_HWDATA = '0;
`ifdef AHB_ARB_LOCK_EN
        m_HMASTLOCK = '0;
`endif
        all_idle();

        // Reset with every manager requesting, then plain round-robin of SINGLEs
        for (int i = 0; i < int'(M); i++)
            set_mgr(i, NONSEQ, 32'h1000 + 32'(i) * 32'h10, SINGLE, 1'b0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_htrans", s_HTRANS, 2'b00);
        chk("rst_hready", m_HREADY, 4'hF);
        chk("rst_hmaster", HMASTER, 0);
        chk("rst_hgrant", HGRANT, 4'b0001);
        chk("rst_hresp", m_HRESP, 0);
        chk("rst_hrdata", m_HRDATA, 0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < int'(M); i++)
                push(2'(i), 32'h1000 + 32'(i) * 32'h10, NONSEQ, 1'b0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        repeat (8) step();
        all_idle();
        step(); step();

        // INCR4 from mgr0 holds the bus against a pending SINGLE from mgr2
        set_mgr(2, NONSEQ, 32'h200, SINGLE, 1'b0);
        for (int b = 0; b < 4; b++)
            push(2'd0, 32'h100 + 32'(b) * 4, (b == 0) ? NONSEQ : SEQ, 1'b0);
        push(2'd2, 32'h200, NONSEQ, 1'b0);
        for (int b = 0; b < 4; b++) begin
            set_mgr(0, (b == 0) ? NONSEQ : SEQ, 32'h100 + 32'(b) * 4, INCR4, 1'b0);
            @(negedge HCLK);
            chk("inc4_hready2_low", m_HREADY[2], 1'b0);
            step();
        end
        set_mgr(0, IDLE, 32'h0, SINGLE, 1'b0);
        @(negedge HCLK);
        chk("inc4_hmaster2", HMASTER, 2);
        chk("inc4_hready2_high", m_HREADY[2], 1'b1);
        step();
        set_mgr(2, IDLE, 32'h0, SINGLE, 1'b0);
        step();

        // mgr1 write with three subordinate wait states
        m_HWDATA[DW*1 +: DW] = 32'hDEADBEEF;
        set_mgr(1, NONSEQ, 32'h300, SINGLE, 1'b1);
        push(2'd1, 32'h300, NONSEQ, 1'b1);
        step(); step();
        set_mgr(1, IDLE, 32'h0, SINGLE, 1'b0);
        s_HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(negedge HCLK);
            chk("ws_hwdata", s_HWDATA, 32'hDEADBEEF);
            chk("ws_hready1", m_HREADY[1], 1'b0);
            chk("ws_hmaster", HMASTER, 1);
            step();
        end
        s_HREADY = 1'b1;
        @(negedge HCLK);
        chk("ws_done_hready1", m_HREADY[1], 1'b1);
        chk("ws_done_hwdata", s_HWDATA, 32'hDEADBEEF);
        step();

        // mgr0 undefined-length INCR, terminated by IDLE after six beats; mgr3 waits
        set_mgr(0, NONSEQ, 32'h400, INCR, 1'b0);
        step();
        set_mgr(3, NONSEQ, 32'h500, SINGLE, 1'b0);
        for (int b = 0; b < 6; b++)
            push(2'd0, 32'h400 + 32'(b) * 4, (b == 0) ? NONSEQ : SEQ, 1'b0);
        push(2'd3, 32'h500, NONSEQ, 1'b0);
        for (int b = 0; b < 6; b++) begin
            set_mgr(0, (b == 0) ? NONSEQ : SEQ, 32'h400 + 32'(b) * 4, INCR, 1'b0);
            if (b == 4) begin
                @(negedge HCLK);
                chk("incr_hready3_low", m_HREADY[3], 1'b0);
            end
            step();
        end
        set_mgr(0, IDLE, 32'h0, SINGLE, 1'b0);
        @(negedge HCLK);
        chk("incr_idle_hmaster0", HMASTER, 0);
        step();
        @(negedge HCLK);
        chk("incr_after_hmaster3", HMASTER, 3);
        step();
        set_mgr(3, IDLE, 32'h0, SINGLE, 1'b0);

        // Error response on a mgr2 read goes to mgr2 only
        set_mgr(2, NONSEQ, 32'h600, SINGLE, 1'b0);
        push(2'd2, 32'h600, NONSEQ, 1'b0);
        step(); step();
        set_mgr(2, IDLE, 32'h0, SINGLE, 1'b0);
        s_HRESP  = 1'b1;
        s_HRDATA = 32'h12345678;
        @(negedge HCLK);
        chk("err_hresp", m_HRESP, 4'b0100);
        chk("err_hrdata", m_HRDATA, 128'h00000000_12345678_00000000_00000000);
        chk("err_hready", m_HREADY, 4'b0100);
        chk("err_hmaster", HMASTER, 2);
        step();
        s_HRESP  = 1'b0;
        s_HRDATA = '0;
        step();

        // Reset in the middle of an INCR4 abandons it and returns to the reset state
        set_mgr(2, NONSEQ, 32'h700, INCR4, 1'b0);
        push(2'd2, 32'h700, NONSEQ, 1'b0);
        push(2'd2, 32'h704, SEQ, 1'b0);
        step();
        set_mgr(2, SEQ, 32'h704, INCR4, 1'b0);
        step();
        set_mgr(2, SEQ, 32'h708, INCR4, 1'b0);
        HRESETn = 1'b0;
        @(negedge HCLK);
        chk("midrst_htrans", s_HTRANS, 2'b00);
        chk("midrst_hready", m_HREADY, 4'hF);
        chk("midrst_hmaster", HMASTER, 0);
        chk("midrst_hgrant", HGRANT, 4'b0001);
        step();
        all_idle();
        HRESETn = 1'b1;
        step();
        set_mgr(1, NONSEQ, 32'h720, SINGLE, 1'b0);
        push(2'd1, 32'h720, NONSEQ, 1'b0);
        step(); step();
        set_mgr(1, IDLE, 32'h0, SINGLE, 1'b0);
        @(negedge HCLK);
        chk("postrst_park_hmaster1", HMASTER, 1);
        step();

`ifdef AHB_ARB_LOCK_EN
        // HMASTLOCK on mgr1 keeps the grant across two SINGLEs while mgr0 waits
        m_HMASTLOCK[1] = 1'b1;
        set_mgr(1, NONSEQ, 32'h800, SINGLE, 1'b0);
        set_mgr(0, NONSEQ, 32'h900, SINGLE, 1'b0);
        push(2'd1, 32'h800, NONSEQ, 1'b0);
        push(2'd1, 32'h804, NONSEQ, 1'b0);
        push(2'd0, 32'h900, NONSEQ, 1'b0);
        @(negedge HCLK);
        chk("lock_s_mastlock", s_HMASTLOCK, 1'b1);
        step();
        set_mgr(1, NONSEQ, 32'h804, SINGLE, 1'b0);
        step();
        set_mgr(1, IDLE, 32'h0, SINGLE, 1'b0);
        m_HMASTLOCK[1] = 1'b0;
        @(negedge HCLK);
        chk("lock_hold_hmaster1", HMASTER, 1);
        step();
        @(negedge HCLK);
        chk("lock_release_hmaster0", HMASTER, 0);
        step();
        set_mgr(0, IDLE, 32'h0, SINGLE, 1'b0);
`endif

        step(); step();
        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
